hpm_event_counters: RTL and testbench
=====================================

# hpm_event_counters

Parametrised hardware performance-monitor block replacing the fixed-function counter bank. It provides NR_COUNTERS counters, each bound at run time to any of NR_EVENTS event inputs through a writable selector. Events carry multi-bit per-cycle increments, so multi-port commit events count correctly. Per-counter inhibit, sticky overflow status and an overflow interrupt are included. It sits beside the CSR file and is accessed through the same SRAM-like read/write port.

## Interface
- NR_COUNTERS, default 4, number of counters (1..16)
- NR_EVENTS, default 16, number of event inputs (1..63)
- CNT_WIDTH, default 64, counter width (8..64)
- INC_WIDTH, default 2, width of each event's per-cycle increment
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- debug_mode_i  in  1  when 1, no counter increments
- addr_i  in  6  register address
- we_i  in  1  write enable
- data_i  in  64  write data
- data_o  out  64  read data (combinational)
- event_i  in  NR_EVENTS x INC_WIDTH  per-cycle increment per event
- ovf_irq_o  out  1  overflow interrupt

## Operation
- Register map; all other addresses read 0 and ignore writes:
  - 0x00+i: counter i (i < NR_COUNTERS)
  - 0x10+i: event selector i, SEL_W = $clog2(NR_EVENTS+1) bits
  - 0x20: inhibit mask, NR_COUNTERS bits
  - 0x21: overflow status, NR_COUNTERS bits; write-1-to-clear
  - 0x22: overflow interrupt enable, NR_COUNTERS bits
- Reads zero-extend to 64 bits. Writes take the low bits of data_i.
- Selector encoding:
  - 0: counter idle.
  - s in 1..NR_EVENTS: counter adds event_i[s-1] each cycle.
  - s > NR_EVENTS: counter idle, and the value still reads back as written.
- Counter i increments when all of these hold: debug_mode_i=0, inhibit[i]=0, selector valid.
- Increment arithmetic:
  - sum = counter + zero-extended increment, computed in CNT_WIDTH+1 bits.
  - The counter takes the low CNT_WIDTH bits, so it wraps modulo 2^CNT_WIDTH.
  - A carry out sets ovf[i]. ovf[i] is sticky.
- Software write to counter i in the same cycle as an increment: the write wins, no increment is applied, and no overflow is flagged.
- Write-1-clear of ovf[i] in the same cycle as a new overflow of counter i: the set wins and ovf[i] stays 1.
- Multiple counters may select the same event; each counts independently.
- ovf_irq_o = |(ovf_q & ovf_en_q), driven from registers only.
- Reset values:
  - counters, selectors, inhibit, ovf, ovf_en: 0
  - ovf_irq_o: 0
  - data_o: 0 for every address

## Timing
- data_o is combinational from addr_i and register state. A read returns the pre-write value in a write cycle (write-after-read).
- A write is visible to reads in the cycle after we_i.
- An event in cycle N is visible in the counter at cycle N+1.
- Overflow in cycle N:
  - ovf[i] reads 1 at cycle N+1.
  - ovf_irq_o rises at cycle N+1 if enabled.
- Clearing the last enabled ovf bit drops ovf_irq_o the following cycle.
- Enabling ovf_en for a bit that is already set raises ovf_irq_o the following cycle.
- Changing a selector or the inhibit mask affects counting from the cycle after the write. The write cycle itself uses the old configuration.
- Asynchronous reset mid-operation clears all state immediately; counting resumes on the first clock after deassertion.

## Test plan
- Reset, then read every mapped address and 0x3F.
  - All reads return 0 and ovf_irq_o=0.
- Write sel0=3 and drive event_i[2]=2 for 10 cycles.
  - Counter 0 reads 20.
  - Counter 1, with sel1=0, reads 0.
- CNT_WIDTH=8 build, then:
  - Write counter0=0xFE, ovf_en=1, sel0=1, and drive event_i[0]=3 for 1 cycle.
  - Counter0 reads 0x01; ovf reads 0x1; ovf_irq_o=1 on the next cycle.
  - Write 0x1 to 0x21: ovf_irq_o falls one cycle later.
- Simultaneous events in the same cycle:
  - Counter write 0x100 with event increment 1: counter reads 0x100.
  - W1C of ovf with a new overflow: ovf stays 1.
- Set inhibit=0x2 and debug_mode_i pulses, with sel0=sel1=1 and event_i[0]=1 for 8 cycles, 2 of them in debug.
  - Counter0=6, counter1=0.
- Write sel0=NR_EVENTS+1 and drive all events high.
  - Counter0 stays 0; sel0 reads back NR_EVENTS+1.

Source files
------------

// File: rtl/hpm_event_counters.sv
// -----------------------------------------------------------------------------
// hpm_event_counters
//
// Hardware performance-monitor counter bank. Each of NR_COUNTERS counters is
// bound at run time to one of NR_EVENTS event inputs through a writable
// selector. Every event supplies a multi-bit increment per cycle. Each counter
// has an inhibit bit, a sticky overflow flag, and an overflow interrupt enable.
// Software reaches the bank through an SRAM-like port with combinational reads.
//
// Register map (all other addresses read 0 and ignore writes):
//   0x00+i : counter i
//   0x10+i : event selector i (0 = idle, 1..NR_EVENTS = event s-1, else idle)
//   0x20   : inhibit mask
//   0x21   : overflow status, write-1-to-clear
//   0x22   : overflow interrupt enable
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   debug_mode_i  freezes all counters while high
//   addr_i        register address
//   we_i          write enable
//   data_i        write data (low bits used)
//   data_o        read data, zero-extended, combinational
//   event_i       per-cycle increment for each event
//   ovf_irq_o     OR of enabled overflow flags
// -----------------------------------------------------------------------------
module hpm_event_counters #(
    parameter int NR_COUNTERS = 4,
    parameter int NR_EVENTS   = 16,
    parameter int CNT_WIDTH   = 64,
    parameter int INC_WIDTH   = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                debug_mode_i,
    input  logic [5:0]                          addr_i,
    input  logic                                we_i,
    input  logic [63:0]                         data_i,
    output logic [63:0]                         data_o,
    input  logic [NR_EVENTS-1:0][INC_WIDTH-1:0] event_i,
    output logic                                ovf_irq_o
);

    localparam int SEL_W = $clog2(NR_EVENTS + 1);
    localparam int SUM_W = CNT_WIDTH + 1;

    localparam logic [5:0] ADDR_INHIBIT = 6'h20;
    localparam logic [5:0] ADDR_OVF     = 6'h21;
    localparam logic [5:0] ADDR_OVF_EN  = 6'h22;

    logic [CNT_WIDTH-1:0]   cnt_q     [NR_COUNTERS];
    logic [CNT_WIDTH-1:0]   cnt_d     [NR_COUNTERS];
    logic [SEL_W-1:0]       sel_q     [NR_COUNTERS];
    logic [SEL_W-1:0]       sel_d     [NR_COUNTERS];
    logic [NR_COUNTERS-1:0] inhibit_q, inhibit_d;
    logic [NR_COUNTERS-1:0] ovf_q,     ovf_d;
    logic [NR_COUNTERS-1:0] ovf_en_q,  ovf_en_d;

    logic [INC_WIDTH-1:0]   inc       [NR_COUNTERS];
    logic [NR_COUNTERS-1:0] sel_valid;
    logic [NR_COUNTERS-1:0] count_en;
    logic [SUM_W-1:0]       sum       [NR_COUNTERS];
    logic [NR_COUNTERS-1:0] ovf_set;

    // Event routing. The selector is compared against every legal code, so
    // out-of-range selector values simply match nothing and leave the counter idle.
    always_comb begin
        for (int i = 0; i < NR_COUNTERS; i++) begin
            inc[i]       = '0;
            sel_valid[i] = 1'b0;
            for (int e = 0; e < NR_EVENTS; e++) begin
                if (sel_q[i] == SEL_W'(e + 1)) begin
                    inc[i]       = event_i[e];
                    sel_valid[i] = 1'b1;
                end
            end
            count_en[i] = sel_valid[i] & ~debug_mode_i & ~inhibit_q[i];
        end
    end

    // Counter update. The sum is one bit wider than the counter so the carry
    // out becomes the overflow indication. A software write to the counter
    // takes priority and suppresses both the increment and the overflow.
    always_comb begin
        ovf_set = '0;
        for (int i = 0; i < NR_COUNTERS; i++) begin
            sum[i]   = {1'b0, cnt_q[i]} + SUM_W'(inc[i]);
            cnt_d[i] = cnt_q[i];
            if (we_i && (addr_i == 6'(i))) begin
                cnt_d[i] = data_i[CNT_WIDTH-1:0];
            end else if (count_en[i]) begin
                cnt_d[i]   = sum[i][CNT_WIDTH-1:0];
                ovf_set[i] = sum[i][CNT_WIDTH];
            end
        end
    end

    // Configuration and status registers. The overflow clear is applied
    // before the new overflow set, so a fresh overflow survives a W1C in the
    // same cycle.
    always_comb begin
        for (int i = 0; i < NR_COUNTERS; i++) begin
            sel_d[i] = sel_q[i];
            if (we_i && (addr_i == 6'(16 + i))) begin
                sel_d[i] = data_i[SEL_W-1:0];
            end
        end
        inhibit_d = inhibit_q;
        ovf_en_d  = ovf_en_q;
        ovf_d     = ovf_q;
        if (we_i && (addr_i == ADDR_INHIBIT)) begin
            inhibit_d = data_i[NR_COUNTERS-1:0];
        end
        if (we_i && (addr_i == ADDR_OVF_EN)) begin
            ovf_en_d = data_i[NR_COUNTERS-1:0];
        end
        if (we_i && (addr_i == ADDR_OVF)) begin
            ovf_d = ovf_q & ~data_i[NR_COUNTERS-1:0];
        end
        ovf_d = ovf_d | ovf_set;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_COUNTERS; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
            inhibit_q <= '0;
            ovf_q     <= '0;
            ovf_en_q  <= '0;
        end else begin
            for (int i = 0; i < NR_COUNTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
                sel_q[i] <= sel_d[i];
            end
            inhibit_q <= inhibit_d;
            ovf_q     <= ovf_d;
            ovf_en_q  <= ovf_en_d;
        end
    end

    // Read mux: zero-extended register contents, pre-write values in a
    // write cycle since it looks only at the current register state.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < NR_COUNTERS; i++) begin
            if (addr_i == 6'(i)) begin
                data_o[CNT_WIDTH-1:0] = cnt_q[i];
            end
            if (addr_i == 6'(16 + i)) begin
                data_o[SEL_W-1:0] = sel_q[i];
            end
        end
        case (addr_i)
            ADDR_INHIBIT: data_o[NR_COUNTERS-1:0] = inhibit_q;
            ADDR_OVF:     data_o[NR_COUNTERS-1:0] = ovf_q;
            ADDR_OVF_EN:  data_o[NR_COUNTERS-1:0] = ovf_en_q;
            default:      ;
        endcase
    end

    assign ovf_irq_o = |(ovf_q & ovf_en_q);

endmodule

// File: tb/tb_hpm_event_counters.sv
// -----------------------------------------------------------------------------
// tb_hpm_event_counters
//
// Two instances share one stimulus stream: a default 64-bit build and an
// 8-bit build where wrap-around and overflow are easy to reach. A behavioural
// model tracks both register files with plain arithmetic and predicts every
// read and the interrupt line, cycle by cycle.
// -----------------------------------------------------------------------------
module tb_hpm_event_counters;

    localparam int NC = 4;
    localparam int NE = 16;
    localparam int IW = 2;
    localparam int SW = 5;

    typedef logic [NE-1:0][IW-1:0] eventVec_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        debug = 1'b0;
    logic [5:0]  addr = '0;
    logic        we = 1'b0;
    logic [63:0] wdata = '0;
    eventVec_t   ev = '0;
    logic [63:0] rdata64, rdata8;
    logic        irq64, irq8;

    int nChecks = 0;
    int nBad    = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    hpm_event_counters #(
        .NR_COUNTERS(NC), .NR_EVENTS(NE), .CNT_WIDTH(64), .INC_WIDTH(IW)
    ) dut64 (
        .clk_i(clk), .rst_ni(rstN), .debug_mode_i(debug), .addr_i(addr),
        .we_i(we), .data_i(wdata), .data_o(rdata64), .event_i(ev),
        .ovf_irq_o(irq64)
    );

    hpm_event_counters #(
        .NR_COUNTERS(NC), .NR_EVENTS(NE), .CNT_WIDTH(8), .INC_WIDTH(IW)
    ) dut8 (
        .clk_i(clk), .rst_ni(rstN), .debug_mode_i(debug), .addr_i(addr),
        .we_i(we), .data_i(wdata), .data_o(rdata8), .event_i(ev),
        .ovf_irq_o(irq8)
    );

    // Reference state; index 0 is the 64-bit build, index 1 the 8-bit build.
    logic [63:0]    mCnt [2][NC];
    logic [NC-1:0]  mOvf [2];
    logic [SW-1:0]  mSel [NC];
    logic [NC-1:0]  mInh;
    logic [NC-1:0]  mEn;

    // Largest value a counter of the given build can hold.
    function automatic logic [63:0] maxOf(input int k);
        return (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFF;
    endfunction

    // Clear the model, mirroring the documented reset values.
    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NC; i++) mCnt[k][i] = '0;
            mOvf[k] = '0;
        end
        for (int i = 0; i < NC; i++) mSel[i] = '0;
        mInh = '0;
        mEn  = '0;
    endtask

    // Predicted read value for one build at one address.
    function automatic logic [63:0] modelRead(input int k, input logic [5:0] a);
        logic [63:0] r;
        r = '0;
        if (a < NC) r = mCnt[k][a];
        else if (a >= 6'h10 && a < 6'h10 + NC) r = 64'(mSel[a - 6'h10]);
        else if (a == 6'h20) r = 64'(mInh);
        else if (a == 6'h21) r = 64'(mOvf[k]);
        else if (a == 6'h22) r = 64'(mEn);
        return r;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    // Counting uses the configuration from before this cycle's write.
    task automatic modelStep();
        logic [64:0] sumV;
        logic [63:0] lim;
        for (int k = 0; k < 2; k++) begin
            lim = maxOf(k);
            if (we && addr == 6'h21) mOvf[k] = mOvf[k] & ~wdata[NC-1:0];
            for (int i = 0; i < NC; i++) begin
                if (we && addr == 6'(i)) begin
                    mCnt[k][i] = wdata & lim;
                end else if (!debug && !mInh[i] && mSel[i] >= 1 && mSel[i] <= NE) begin
                    sumV = 65'(mCnt[k][i]) + 65'(ev[int'(mSel[i]) - 1]);
                    if (sumV > 65'(lim)) begin
                        mOvf[k][i] = 1'b1;
                        sumV = sumV - 65'(lim) - 65'd1;
                    end
                    mCnt[k][i] = sumV[63:0];
                end
            end
        end
        for (int i = 0; i < NC; i++) begin
            if (we && addr == 6'(16 + i)) mSel[i] = wdata[SW-1:0];
        end
        if (we && addr == 6'h20) mInh = wdata[NC-1:0];
        if (we && addr == 6'h22) mEn  = wdata[NC-1:0];
    endtask

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive inputs after the falling edge, check reads and the
    // interrupt against the model, then let the rising edge update the model.
    task automatic applyStimulus(input logic [5:0] a, input logic w, input logic [63:0] d,
                                 input eventVec_t e, input logic dbg);
        @(negedge clk);
        addr = a; we = w; wdata = d; ev = e; debug = dbg;
        #1;
        checkOutput("rd64", rdata64, modelRead(0, a));
        checkOutput("rd8", rdata8, modelRead(1, a));
        checkOutput("irq64", 64'(irq64), 64'(|(mOvf[0] & mEn)));
        checkOutput("irq8", 64'(irq8), 64'(|(mOvf[1] & mEn)));
        @(posedge clk);
        modelStep();
    endtask

    // Idle read cycle with hand-computed expectations for both builds.
    task automatic checkRead(input string tag, input logic [5:0] a,
                             input logic [63:0] e64, input logic [63:0] e8,
                             input logic i64, input logic i8);
        @(negedge clk);
        addr = a; we = 1'b0; wdata = '0; ev = '0; debug = 1'b0;
        #1;
        checkOutput({tag, "_64"}, rdata64, e64);
        checkOutput({tag, "_8"}, rdata8, e8);
        checkOutput({tag, "_irq64"}, 64'(irq64), 64'(i64));
        checkOutput({tag, "_irq8"}, 64'(irq8), 64'(i8));
        @(posedge clk);
        modelStep();
    endtask

    function automatic eventVec_t evOne(input int idx, input logic [IW-1:0] val);
        eventVec_t e;
        e = '0;
        e[idx] = val;
        return e;
    endfunction

    task automatic writeReg(input logic [5:0] a, input logic [63:0] d);
        applyStimulus(a, 1'b1, d, '0, 1'b0);
    endtask

    // Random address biased toward the mapped registers.
    function automatic logic [5:0] pickAddr();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1, 2, 3: return 6'(r);
            4:          return 6'(16 + $urandom_range(0, NC - 1));
            5:          return 6'h20;
            6:          return 6'h21;
            7:          return 6'h22;
            8:          return 6'($urandom);
            default:    return 6'($urandom_range(0, NC - 1));
        endcase
    endfunction

    // Main sequence: reset checks, directed scenarios, async reset, then random.
    initial begin
        logic [5:0]  resetAddrs [12];
        logic [5:0]  a;
        logic        w;
        logic [63:0] d;
        eventVec_t   e;

        resetAddrs = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h10, 6'h11,
                       6'h12, 6'h13, 6'h20, 6'h21, 6'h22, 6'h3F};
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;

        foreach (resetAddrs[j]) checkRead("reset", resetAddrs[j], 64'h0, 64'h0, 1'b0, 1'b0);

        // Selector 3 follows event 2 at +2 per cycle; counter 1 stays idle.
        writeReg(6'h10, 64'd3);
        repeat (10) applyStimulus(6'h00, 1'b0, '0, evOne(2, 2'd2), 1'b0);
        checkRead("cnt0_20", 6'h00, 64'd20, 64'd20, 1'b0, 1'b0);
        checkRead("cnt1_0", 6'h01, 64'd0, 64'd0, 1'b0, 1'b0);

        // Overflow and interrupt on the 8-bit build.
        writeReg(6'h00, 64'hFE);
        writeReg(6'h22, 64'h1);
        writeReg(6'h10, 64'h1);
        applyStimulus(6'h00, 1'b0, '0, evOne(0, 2'd3), 1'b0);
        checkRead("ovf_cnt", 6'h00, 64'h101, 64'h01, 1'b0, 1'b1);
        checkRead("ovf_flag", 6'h21, 64'h0, 64'h1, 1'b0, 1'b1);
        applyStimulus(6'h21, 1'b1, 64'h1, '0, 1'b0);
        checkRead("ovf_clr", 6'h21, 64'h0, 64'h0, 1'b0, 1'b0);

        // Counter write collides with an increment: the write wins.
        applyStimulus(6'h00, 1'b1, 64'h100, evOne(0, 2'd1), 1'b0);
        checkRead("wr_wins", 6'h00, 64'h100, 64'h00, 1'b0, 1'b0);

        // W1C collides with a fresh overflow: the flag stays set.
        writeReg(6'h00, 64'hFF);
        applyStimulus(6'h00, 1'b0, '0, evOne(0, 2'd1), 1'b0);
        writeReg(6'h00, 64'hFF);
        applyStimulus(6'h21, 1'b1, 64'h1, evOne(0, 2'd1), 1'b0);
        checkRead("set_wins", 6'h21, 64'h0, 64'h1, 1'b0, 1'b1);
        writeReg(6'h21, 64'hF);
        writeReg(6'h00, 64'h0);

        // Inhibit on counter 1 and two debug cycles out of eight.
        writeReg(6'h11, 64'h1);
        writeReg(6'h20, 64'h2);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(6'h00, 1'b0, '0, evOne(0, 2'd1), (i == 2 || i == 5));
        end
        checkRead("inh_cnt0", 6'h00, 64'd6, 64'd6, 1'b0, 1'b0);
        checkRead("inh_cnt1", 6'h01, 64'd0, 64'd0, 1'b0, 1'b0);

        // Out-of-range selector: idle but reads back as written.
        writeReg(6'h20, 64'h0);
        writeReg(6'h00, 64'h0);
        writeReg(6'h10, 64'(NE + 1));
        repeat (5) applyStimulus(6'h00, 1'b0, '0, '1, 1'b0);
        checkRead("badsel_cnt", 6'h00, 64'd0, 64'd0, 1'b0, 1'b0);
        checkRead("badsel_rd", 6'h10, 64'(NE + 1), 64'(NE + 1), 1'b0, 1'b0);
        checkRead("cnt1_15", 6'h01, 64'd15, 64'd15, 1'b0, 1'b0);

        // Asynchronous reset between clock edges clears state at once.
        @(negedge clk);
        addr = 6'h01; we = 1'b0; ev = '0; debug = 1'b0;
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("async_rst64", rdata64, 64'h0);
        checkOutput("async_rst8", rdata8, 64'h0);
        modelReset();
        @(negedge clk);
        rstN = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            a = pickAddr();
            w = ($urandom_range(0, 9) < 3);
            d = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       d[7:0] = 8'hF0 | 8'($urandom_range(0, 15));
                1:       d = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: ;
            endcase
            if (a >= 6'h10 && a < 6'h10 + NC) d[SW-1:0] = SW'($urandom_range(0, 20));
            e = {$urandom};
            applyStimulus(a, w, d, e, ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
